// File: rtl/lock_ctrl.sv
// Keypad lock controller: buffers four BCD digits, checks them against a stored
// password, and handles unlock, relock, lockout after repeated mismatches and password change.
module lock_ctrl #(
  parameter logic [15:0] INIT_PW      = 16'h1234,
  parameter int          MAX_ERR      = 3,
  parameter int          FAIL_CYCLES  = 8,
  parameter int          ALARM_CYCLES = 16,
  parameter int          OPEN_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit,
  input  logic       digit_vld,
  input  logic       back,
  input  logic       lock,
  input  logic       chg,
  output logic [2:0] state,
  output logic [2:0] ndig,
  output logic       unlocked,
  output logic       fail,
  output logic       alarm,
  output logic [1:0] err_cnt,
  output logic       pw_upd
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_CHECK = 3'd2,
    S_OPEN  = 3'd3,
    S_FAIL  = 3'd4,
    S_ALARM = 3'd5,
    S_SET   = 3'd6,
    S_BAD   = 3'd7
  } state_e;

  localparam logic [23:0] FAIL_LAST  = 24'(FAIL_CYCLES - 1);
  localparam logic [23:0] ALARM_LAST = 24'(ALARM_CYCLES - 1);
  localparam logic [23:0] OPEN_LAST  = 24'(OPEN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  ndig_q, ndig_d;
  logic [15:0] buf_q, buf_d;
  logic [15:0] pw_q, pw_d;
  logic [1:0]  err_q, err_d;
  logic [23:0] timer_q, timer_d;
  logic        pw_upd_q, pw_upd_d;

  logic        digit_ok, back_ev, chg_ev, lock_ev, last_digit;
  logic [15:0] buf_ins;
  logic [2:0]  err_inc;

  // Control inputs are single-cycle strobes with no ready/backpressure: an event
  // is consumed on the edge it is sampled high, and lower-priority strobes in that cycle are dropped.
  assign digit_ok   = digit_vld && (digit <= 4'd9);
  assign back_ev    = !digit_ok && back;
  assign chg_ev     = !digit_ok && !back && chg;
  assign lock_ev    = !digit_ok && !back && !chg && lock;
  assign last_digit = (ndig_q == 3'd3);
  assign err_inc    = {1'b0, err_q} + 3'd1;

  always_comb begin
    buf_ins = buf_q;
    case (ndig_q)
      3'd0:    buf_ins[15:12] = digit;
      3'd1:    buf_ins[11:8]  = digit;
      3'd2:    buf_ins[7:4]   = digit;
      3'd3:    buf_ins[3:0]   = digit;
      default: buf_ins = buf_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ndig_d   = ndig_q;
    buf_d    = buf_q;
    pw_d     = pw_q;
    err_d    = err_q;
    pw_upd_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (digit_ok) begin
          buf_d   = {digit, 12'hFFF};
          ndig_d  = 3'd1;
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (digit_ok) begin
          buf_d  = buf_ins;
          ndig_d = ndig_q + 3'd1;
          if (last_digit) state_d = S_CHECK;
        end else if (back_ev && ndig_q != 3'd0) begin
          ndig_d = ndig_q - 3'd1;
          if (ndig_q == 3'd1) state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        ndig_d = 3'd0;
        buf_d  = 16'hFFFF;
        if (buf_q == pw_q) begin
          err_d   = 2'd0;
          state_d = S_OPEN;
        end else begin
          err_d   = err_inc[1:0];
          state_d = (err_inc == 3'(MAX_ERR)) ? S_ALARM : S_FAIL;
        end
      end
      S_OPEN: begin
        if (chg_ev) begin
          ndig_d  = 3'd0;
          buf_d   = 16'hFFFF;
          state_d = S_SET;
        end else if (lock_ev || timer_q >= OPEN_LAST) begin
          state_d = S_IDLE;
        end
      end
      S_FAIL: begin
        if (timer_q >= FAIL_LAST) state_d = S_IDLE;
      end
      S_ALARM: begin
        if (timer_q >= ALARM_LAST) begin
          err_d   = 2'd0;
          state_d = S_IDLE;
        end
      end
      S_SET: begin
        if (digit_ok) begin
          if (last_digit) begin
            pw_d     = buf_ins;
            pw_upd_d = 1'b1;
            ndig_d   = 3'd0;
            buf_d    = 16'hFFFF;
            state_d  = S_IDLE;
          end else begin
            buf_d  = buf_ins;
            ndig_d = ndig_q + 3'd1;
          end
        end else if (back_ev) begin
          if (ndig_q != 3'd0) ndig_d = ndig_q - 3'd1;
        end else if (lock_ev) begin
          ndig_d  = 3'd0;
          buf_d   = 16'hFFFF;
          state_d = S_IDLE;
        end
      end
      default: begin
        ndig_d  = 3'd0;
        buf_d   = 16'hFFFF;
        state_d = S_IDLE;
      end
    endcase
  end

  // Dwell timer restarts on every state change so each timed state counts from its entry.
  assign timer_d = (state_d != state_q) ? 24'd0 : timer_q + 24'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ndig_q   <= 3'd0;
      buf_q    <= 16'hFFFF;
      pw_q     <= INIT_PW;
      err_q    <= 2'd0;
      timer_q  <= 24'd0;
      pw_upd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ndig_q   <= ndig_d;
      buf_q    <= buf_d;
      pw_q     <= pw_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
      pw_upd_q <= pw_upd_d;
    end
  end

  assign state    = state_q;
  assign ndig     = ndig_q;
  assign unlocked = (state_q == S_OPEN);
  assign fail     = (state_q == S_FAIL);
  assign alarm    = (state_q == S_ALARM);
  assign err_cnt  = err_q;
  assign pw_upd   = pw_upd_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Bench for lock_ctrl: scenario tasks with inline checks, plus a scoreboard of
// expected CHECK outcomes popped when the FSM leaves CHECK.
module tb_lock_ctrl;

  localparam logic [2:0]  ST_IDLE  = 3'd0;
  localparam logic [2:0]  ST_ENTRY = 3'd1;
  localparam logic [2:0]  ST_CHECK = 3'd2;
  localparam logic [2:0]  ST_OPEN  = 3'd3;
  localparam logic [2:0]  ST_FAIL  = 3'd4;
  localparam logic [2:0]  ST_ALARM = 3'd5;
  localparam logic [2:0]  ST_SET   = 3'd6;
  localparam logic [15:0] INIT_PW  = 16'h1234;
  localparam int          MAX_ERR  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit = 4'd0;
  logic       digit_vld = 1'b0;
  logic       back = 1'b0;
  logic       lock = 1'b0;
  logic       chg = 1'b0;
  logic [2:0] state;
  logic [2:0] ndig;
  logic       unlocked, fail, alarm, pw_upd;
  logic [1:0] err_cnt;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [2:0]  exp_q[$];
  logic [2:0]  exp_v;
  logic [2:0]  prev_state = 3'd0;
  logic [15:0] model_pw = INIT_PW;
  int          model_err = 0;

  lock_ctrl dut (
    .clk(clk), .rst(rst), .digit(digit), .digit_vld(digit_vld), .back(back),
    .lock(lock), .chg(chg), .state(state), .ndig(ndig), .unlocked(unlocked),
    .fail(fail), .alarm(alarm), .err_cnt(err_cnt), .pw_upd(pw_upd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  // Scoreboard consumer: each exit from CHECK pops one expected destination state.
  always @(negedge clk) begin
    if (!rst && prev_state == ST_CHECK) begin
      tests_run++;
      if (state === ST_CHECK) begin
        tests_failed++;
        $display("FAIL check_len: state=%0d on 2nd cycle, required exit from CHECK", state);
      end else if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected: state=%0d with empty queue, required no result", state);
      end else begin
        exp_v = exp_q.pop_front();
        if (state !== exp_v) begin
          tests_failed++;
          $display("FAIL sb_result: state=%0d, required %0d", state, exp_v);
        end
      end
    end
    prev_state = state;
  end

  task automatic drive_cycle(input logic v, input logic [3:0] d, input logic b,
                             input logic c, input logic l);
    @(posedge clk); #1;
    digit_vld = v; digit = d; back = b; chg = c; lock = l;
    @(posedge clk); #1;
    digit_vld = 1'b0; back = 1'b0; chg = 1'b0; lock = 1'b0;
  endtask

  task automatic push_expect(input logic [15:0] code);
    if (code == model_pw) begin
      model_err = 0;
      exp_q.push_back(ST_OPEN);
    end else begin
      model_err++;
      if (model_err == MAX_ERR) begin
        exp_q.push_back(ST_ALARM);
        model_err = 0;
      end else begin
        exp_q.push_back(ST_FAIL);
      end
    end
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) push_expect(code);
      drive_cycle(1'b1, code[15-4*i -: 4], 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic measure_dwell(input logic [2:0] st, output int n);
    n = 0;
    while (state === st && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (state !== ST_IDLE && k < 300) begin
      @(negedge clk);
      k++;
    end
    tests_run++;
    if (state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL idle_wait: state=%0d, required %0d", state, ST_IDLE);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_pw = INIT_PW;
    model_err = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if (state !== ST_IDLE || ndig !== 3'd0 || err_cnt !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_state: state=%0d ndig=%0d err=%0d, required 0 0 0", state, ndig, err_cnt);
    end
    tests_run++;
    if ({unlocked, fail, alarm, pw_upd} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: flags=%b, required 0000", {unlocked, fail, alarm, pw_upd});
    end
    rst = 1'b0;
    model_pw = INIT_PW;
    model_err = 0;
  endtask

  task automatic test_unlock();
    int n;
    enter_code(16'h1234);
    tests_run++;
    if (state !== ST_CHECK || ndig !== 3'd4) begin
      tests_failed++;
      $display("FAIL unlock_check: state=%0d ndig=%0d, required %0d 4", state, ndig, ST_CHECK);
    end
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (unlocked !== 1'b1 || err_cnt !== 2'd0 || ndig !== 3'd0) begin
      tests_failed++;
      $display("FAIL unlock_open: unlocked=%b err=%0d ndig=%0d, required 1 0 0", unlocked, err_cnt, ndig);
    end
    measure_dwell(ST_OPEN, n);
    tests_run++;
    if (n !== 32 || state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL open_timeout: cycles=%0d state=%0d, required 32 %0d", n, state, ST_IDLE);
    end
  endtask

  task automatic test_fail();
    int n;
    enter_code(16'h1235);
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (fail !== 1'b1 || err_cnt !== 2'd1) begin
      tests_failed++;
      $display("FAIL fail_state: fail=%b err=%0d, required 1 1", fail, err_cnt);
    end
    measure_dwell(ST_FAIL, n);
    tests_run++;
    if (n !== 8 || state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL fail_dwell: cycles=%0d state=%0d, required 8 %0d", n, state, ST_IDLE);
    end
  endtask

  task automatic test_alarm();
    int n;
    logic nd_bad;
    apply_reset();
    enter_code(16'h5555);
    wait_idle();
    tests_run++;
    if (err_cnt !== 2'd1) begin
      tests_failed++;
      $display("FAIL alarm_err1: err=%0d, required 1", err_cnt);
    end
    enter_code(16'h6666);
    wait_idle();
    tests_run++;
    if (err_cnt !== 2'd2) begin
      tests_failed++;
      $display("FAIL alarm_err2: err=%0d, required 2", err_cnt);
    end
    enter_code(16'h7777);
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (alarm !== 1'b1 || err_cnt !== 2'd3) begin
      tests_failed++;
      $display("FAIL alarm_enter: alarm=%b err=%0d, required 1 3", alarm, err_cnt);
    end
    n = 0;
    nd_bad = 1'b0;
    while (state === ST_ALARM && n < 200) begin
      digit_vld = (n == 2 || n == 6);
      digit = 4'($urandom_range(0, 9));
      n++;
      @(negedge clk);
      if (ndig !== 3'd0) nd_bad = 1'b1;
    end
    digit_vld = 1'b0;
    tests_run++;
    if (nd_bad !== 1'b0) begin
      tests_failed++;
      $display("FAIL alarm_ndig: ndig changed=%b, required 0", nd_bad);
    end
    tests_run++;
    if (n !== 16 || state !== ST_IDLE || err_cnt !== 2'd0) begin
      tests_failed++;
      $display("FAIL alarm_dwell: cycles=%0d state=%0d err=%0d, required 16 0 0", n, state, err_cnt);
    end
  endtask

  task automatic test_back();
    drive_cycle(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (state !== ST_IDLE || ndig !== 3'd0) begin
      tests_failed++;
      $display("FAIL bad_digit: state=%0d ndig=%0d, required 0 0", state, ndig);
    end
    drive_cycle(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (ndig !== 3'd3) begin
      tests_failed++;
      $display("FAIL back_n3: ndig=%0d, required 3", ndig);
    end
    drive_cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (ndig !== 3'd2) begin
      tests_failed++;
      $display("FAIL back_n2: ndig=%0d, required 2", ndig);
    end
    drive_cycle(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    push_expect(16'h1234);
    drive_cycle(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (ndig !== 3'd4 || state !== ST_CHECK) begin
      tests_failed++;
      $display("FAIL back_n4: ndig=%0d state=%0d, required 4 %0d", ndig, state, ST_CHECK);
    end
    @(negedge clk);
    @(negedge clk);
    drive_cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL relock: state=%0d, required %0d", state, ST_IDLE);
    end
    drive_cycle(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (ndig !== 3'd2 || state !== ST_ENTRY) begin
      tests_failed++;
      $display("FAIL digit_over_back: ndig=%0d state=%0d, required 2 %0d", ndig, state, ST_ENTRY);
    end
    drive_cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (state !== ST_IDLE || ndig !== 3'd0) begin
      tests_failed++;
      $display("FAIL back_to_idle: state=%0d ndig=%0d, required 0 0", state, ndig);
    end
  endtask

  task automatic test_change();
    enter_code(16'h1234);
    @(negedge clk);
    @(negedge clk);
    drive_cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (state !== ST_SET || ndig !== 3'd0) begin
      tests_failed++;
      $display("FAIL chg_set: state=%0d ndig=%0d, required %0d 0", state, ndig, ST_SET);
    end
    drive_cycle(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    model_pw = 16'h9876;
    tests_run++;
    if (pw_upd !== 1'b1 || state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL pw_upd_pulse: pw_upd=%b state=%0d, required 1 0", pw_upd, state);
    end
    @(posedge clk); #1;
    tests_run++;
    if (pw_upd !== 1'b0) begin
      tests_failed++;
      $display("FAIL pw_upd_width: pw_upd=%b, required 0", pw_upd);
    end
    enter_code(16'h1234);
    wait_idle();
    enter_code(16'h9876);
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (unlocked !== 1'b1) begin
      tests_failed++;
      $display("FAIL new_pw_open: unlocked=%b, required 1", unlocked);
    end
    drive_cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    apply_reset();
    enter_code(16'h1234);
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (unlocked !== 1'b1) begin
      tests_failed++;
      $display("FAIL init_pw_restored: unlocked=%b, required 1", unlocked);
    end
    drive_cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_in_set();
    enter_code(16'h1234);
    @(negedge clk);
    @(negedge clk);
    drive_cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    drive_cycle(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (state !== ST_SET || ndig !== 3'd2) begin
      tests_failed++;
      $display("FAIL set_two: state=%0d ndig=%0d, required %0d 2", state, ndig, ST_SET);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (state !== ST_IDLE || ndig !== 3'd0 || err_cnt !== 2'd0 ||
        {unlocked, fail, alarm, pw_upd} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL async_reset: state=%0d ndig=%0d err=%0d flags=%b, required 0 0 0 0000",
               state, ndig, err_cnt, {unlocked, fail, alarm, pw_upd});
    end
    @(negedge clk);
    rst = 1'b0;
    model_pw = INIT_PW;
    model_err = 0;
    enter_code(16'h1234);
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (unlocked !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_pw_kept: unlocked=%b, required 1", unlocked);
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_fail();
    test_alarm();
    test_back();
    test_change();
    test_reset_in_set();
    repeat (2) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_leftover: %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
